// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the bus widths, the default NOP and the fetch FSM state encoding.
package if_fetch_pkg;

   typedef logic [31:0] inst_addr_t;
   typedef logic [31:0] inst_t;

   localparam inst_t NOP_INST_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   function automatic inst_addr_t align_word(input inst_addr_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_pc_reg.sv
// PC register for the fetch stage: redirect mux with word alignment, +4 advance
// and the squash flag that marks an in-flight fetch as stale.
import if_fetch_pkg::*;

module if_pc_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   input  logic [31:0] advance_base,
   input  logic        squash_set,
   input  logic        squash_clr,
   output logic [31:0] pc,
   output logic [31:0] redirect_target,
   output logic        squash
);

   assign redirect_target = align_word(redirect_pc);

   // A redirect always wins over the sequential +4 advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= RESET_PC;
         squash <= 1'b0;
      end else begin
         if (redirect) begin
            pc <= redirect_target;
         end else if (advance) begin
            pc <= advance_base + 32'd4;
         end
         if (squash_clr) begin
            squash <= 1'b0;
         end else if (squash_set) begin
            squash <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues word fetches to mem_ctrl, holds the returned
// instruction for ID, and absorbs EX redirects even while a fetch is in flight.
import if_fetch_pkg::*;

module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        if_req,
   output logic [31:0] if_raddr,
   input  logic [31:0] mem_data,
   input  logic        if_mem_ctrl_done,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        id_ready
);

   fetch_state_e state, next_state;

   logic [31:0] pc;
   logic [31:0] redirect_target;
   logic        squash;
   logic        launch;
   logic        fetch_end;
   logic        capture;
   logic        release_inst;
   logic        squash_set;

   if_pc_reg #(
      .RESET_PC(RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .rst            (rst),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .advance        (capture),
      .advance_base   (if_raddr),
      .squash_set     (squash_set),
      .squash_clr     (fetch_end),
      .pc             (pc),
      .redirect_target(redirect_target),
      .squash         (squash)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A fetch that saw a redirect (now or earlier) completes but its word is dropped.
   always_comb begin
      next_state   = state;
      launch       = 1'b0;
      fetch_end    = 1'b0;
      capture      = 1'b0;
      release_inst = 1'b0;
      squash_set   = 1'b0;
      case (state)
         S_IDLE: begin
            launch     = 1'b1;
            next_state = S_REQ;
         end
         S_REQ: begin
            if (if_mem_ctrl_done) begin
               fetch_end = 1'b1;
               if (!squash && !redirect) begin
                  capture    = 1'b1;
                  next_state = S_HOLD;
               end else begin
                  next_state = S_IDLE;
               end
            end else if (redirect) begin
               squash_set = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect || id_ready) begin
               release_inst = 1'b1;
               next_state   = S_IDLE;
            end
         end
         default: begin
            fetch_end    = 1'b1;
            release_inst = 1'b1;
            next_state   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_req     <= 1'b0;
         if_raddr   <= 32'h0;
         inst_valid <= 1'b0;
         inst       <= NOP_INST;
         inst_pc    <= 32'h0;
      end else begin
         if (launch) begin
            if_req   <= 1'b1;
            if_raddr <= redirect ? redirect_target : pc;
         end
         if (fetch_end) begin
            if_req <= 1'b0;
         end
         if (capture) begin
            inst       <= mem_data;
            inst_pc    <= if_raddr;
            inst_valid <= 1'b1;
         end
         if (release_inst) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a transaction-level model tracks which address
// must be fetched next and which words must reach ID, checked every cycle.
module tb_if_fetch;

   localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;
   localparam logic [31:0] TB_NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_raddr;
   logic [31:0] mem_data;
   logic        if_mem_ctrl_done;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        id_ready;

   int errors = 0;
   int checks = 0;

   // Reference model state: phases are 0 idle, 1 fetching, 2 holding for ID.
   logic [31:0] next_pc;
   logic [31:0] cur_addr;
   logic [31:0] held_inst;
   logic [31:0] held_pc;
   bit          discard;
   int          exp_phase;
   int          req_cycles;
   int          lat;
   int          stall;
   int          delivered;

   int p_redirect;
   int p_notready;
   int p_stray;
   int fixed_lat;

   if_fetch #(
      .RESET_PC(TB_RESET_PC),
      .NOP_INST(TB_NOP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .if_req          (if_req),
      .if_raddr        (if_raddr),
      .mem_data        (mem_data),
      .if_mem_ctrl_done(if_mem_ctrl_done),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .id_ready        (id_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] pickTarget();
      logic [31:0] t;
      case ($urandom_range(4))
         0:       t = 32'h0000_0100;
         1:       t = 32'h0000_0203;
         2:       t = 32'hFFFF_FFFC;
         3:       t = 32'hFFFF_FFFF;
         default: t = $urandom;
      endcase
      return t;
   endfunction

   // Samples the outputs for the coming edge, checks them, drives inputs and advances the model.
   task automatic applyStimulus();
      int          ph;
      logic [31:0] tgt;
      logic [31:0] tgt_al;
      logic        do_done;
      ph = if_req ? 1 : (inst_valid ? 2 : 0);
      if (exp_phase >= 0) checkOutput("phase", 32'(ph), 32'(exp_phase));
      if (ph == 1) checkOutput("if_raddr", if_raddr, cur_addr);
      if (ph == 2) begin
         checkOutput("inst", inst, held_inst);
         checkOutput("inst_pc", inst_pc, held_pc);
      end
      if (ph == 0) checkOutput("inst_nop", inst, TB_NOP);

      stall++;
      if (stall > 80) begin
         checkOutput("watchdog", 32'(stall), 32'd0);
         stall = 0;
      end

      redirect = ($urandom_range(99) < p_redirect);
      tgt      = pickTarget();
      tgt_al   = {tgt[31:2], 2'b00};
      redirect_pc = redirect ? tgt : $urandom;
      id_ready = !($urandom_range(99) < p_notready);
      if (ph == 1) begin
         req_cycles++;
         do_done = (req_cycles >= lat);
      end else begin
         do_done = ($urandom_range(99) < p_stray);
      end
      if_mem_ctrl_done = do_done;
      mem_data = (do_done && ph == 1) ? (32'hAAAA_0000 | if_raddr) : $urandom;

      case (ph)
         0: begin
            cur_addr   = redirect ? tgt_al : next_pc;
            next_pc    = cur_addr;
            discard    = 1'b0;
            req_cycles = 0;
            lat        = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 8);
            stall      = 0;
            exp_phase  = 1;
         end
         1: begin
            if (redirect) begin
               next_pc = tgt_al;
               discard = 1'b1;
            end
            if (do_done) begin
               if (discard) begin
                  exp_phase = 0;
               end else begin
                  held_inst = 32'hAAAA_0000 | cur_addr;
                  held_pc   = cur_addr;
                  next_pc   = cur_addr + 32'd4;
                  delivered++;
                  exp_phase = 2;
               end
            end else begin
               exp_phase = 1;
            end
         end
         default: begin
            if (redirect) next_pc = tgt_al;
            exp_phase = (redirect || id_ready) ? 0 : 2;
         end
      endcase
   endtask

   task automatic step();
      @(negedge clk);
      applyStimulus();
   endtask

   // Asserts reset between edges and checks that outputs clear before the next edge.
   task automatic applyReset();
      @(negedge clk);
      redirect         = 1'b0;
      if_mem_ctrl_done = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_if_req", {31'b0, if_req}, 32'd0);
      checkOutput("rst_if_raddr", if_raddr, 32'd0);
      checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("rst_inst", inst, TB_NOP);
      checkOutput("rst_inst_pc", inst_pc, 32'd0);
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      next_pc   = TB_RESET_PC;
      exp_phase = 0;
      stall     = 0;
   endtask

   initial begin
      rst              = 1'b1;
      mem_data         = 32'h0;
      if_mem_ctrl_done = 1'b0;
      redirect         = 1'b0;
      redirect_pc      = 32'h0;
      id_ready         = 1'b0;
      next_pc          = TB_RESET_PC;
      cur_addr         = 32'h0;
      held_inst        = 32'h0;
      held_pc          = 32'h0;
      discard          = 1'b0;
      exp_phase        = -1;
      req_cycles       = 0;
      lat              = 8;
      stall            = 0;
      delivered        = 0;
      p_redirect       = 0;
      p_notready       = 0;
      p_stray          = 0;
      fixed_lat        = 8;

      applyReset();
      applyStimulus();
      repeat (60) step();

      p_notready = 80;
      repeat (150) step();

      p_notready = 30;
      p_redirect = 15;
      p_stray    = 10;
      fixed_lat  = 0;
      repeat (1500) step();

      p_redirect = 0;
      p_stray    = 0;
      fixed_lat  = 8;
      for (int i = 0; i < 40 && !if_req; i++) step();
      checkOutput("req_before_reset", {31'b0, if_req}, 32'd1);
      applyReset();
      applyStimulus();
      p_redirect = 15;
      p_stray    = 10;
      fixed_lat  = 0;
      repeat (500) step();

      checkOutput("delivered_enough", {31'b0, (delivered > 20)}, 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
